// File: rtl/cbf_spectrum_peak_reporter.sv
`default_nettype none
// ============================================================================
// Module   : cbf_spectrum_peak_reporter
// Brief    : Per-frame argmax over the CBF power spectrum; emits a byte-wide
//            report (peak index, then peak power MSB byte first).
// Revision : 1.0 - initial release
// ============================================================================
module cbf_spectrum_peak_reporter #(
    parameter int WORD_LENGTH_POWER  = 88,
    parameter int PHI_SCAN_NUM_STEPS = 51,
    parameter int WORD_LENGTH_OUT    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WORD_LENGTH_POWER-1:0] s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [WORD_LENGTH_OUT-1:0]   m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic                         frame_error
);

    localparam int         POWER_BYTES = (WORD_LENGTH_POWER + 7) / 8;
    localparam int         c_REP_BITS  = POWER_BYTES * 8;
    localparam int         c_PAD_BITS  = c_REP_BITS - WORD_LENGTH_POWER;
    localparam logic [7:0] c_LAST_BIN  = 8'(PHI_SCAN_NUM_STEPS - 1);
    localparam logic [7:0] c_LAST_BYTE = 8'(POWER_BYTES);

    localparam logic [1:0] c_ST_SCAN = 2'd0;
    localparam logic [1:0] c_ST_DROP = 2'd1;
    localparam logic [1:0] c_ST_EMIT = 2'd2;

    logic [1:0]                   r_state;
    logic [1:0]                   w_next_state;
    logic [7:0]                   r_bin_cnt;
    logic [WORD_LENGTH_POWER-1:0] r_max;
    logic [7:0]                   r_idx;
    logic [c_REP_BITS-1:0]        r_rep_shift;
    logic [7:0]                   r_byte_cnt;
    logic                         r_out_valid;
    logic [WORD_LENGTH_OUT-1:0]   r_out_data;
    logic                         r_out_last;
    logic                         r_frame_error;
    logic                         r_in_ready;

    logic                         w_in_hs;
    logic                         w_scan_hs;
    logic                         w_drop_hs;
    logic                         w_at_last_bin;
    logic                         w_take;
    logic [WORD_LENGTH_POWER-1:0] w_upd_max;
    logic [7:0]                   w_upd_idx;
    logic [c_REP_BITS-1:0]        w_pow_pad;
    logic                         w_good;
    logic                         w_short;
    logic                         w_long;
    logic                         w_out_hs;
    logic                         w_out_done;

    assign w_in_hs       = s_axis_tvalid && r_in_ready;
    assign w_scan_hs     = w_in_hs && (r_state == c_ST_SCAN);
    assign w_drop_hs     = w_in_hs && (r_state == c_ST_DROP);
    assign w_at_last_bin = (r_bin_cnt == c_LAST_BIN);

    // Strict compare so that ties keep the lowest bin index.
    assign w_take    = (r_bin_cnt == 8'd0) || (s_axis_tdata > r_max);
    assign w_upd_max = w_take ? s_axis_tdata : r_max;
    assign w_upd_idx = w_take ? r_bin_cnt : r_idx;

    assign w_good  = w_scan_hs &&  s_axis_tlast &&  w_at_last_bin;
    assign w_short = w_scan_hs &&  s_axis_tlast && !w_at_last_bin;
    assign w_long  = w_scan_hs && !s_axis_tlast &&  w_at_last_bin;

    assign w_out_hs   = r_out_valid && m_axis_tready;
    assign w_out_done = w_out_hs && r_out_last;

    generate
        if (c_PAD_BITS > 0) begin : g_pad
            assign w_pow_pad = {{c_PAD_BITS{1'b0}}, w_upd_max};
        end else begin : g_no_pad
            assign w_pow_pad = w_upd_max;
        end
    endgenerate

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_SCAN: begin
                if (w_good) begin
                    w_next_state = c_ST_EMIT;
                end else if (w_long) begin
                    w_next_state = c_ST_DROP;
                end
            end
            c_ST_DROP: begin
                if (w_drop_hs && s_axis_tlast) begin
                    w_next_state = c_ST_SCAN;
                end
            end
            c_ST_EMIT: begin
                if (w_out_done) begin
                    w_next_state = c_ST_SCAN;
                end
            end
            default: w_next_state = c_ST_SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_SCAN;
            r_in_ready    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_in_ready    <= (w_next_state != c_ST_EMIT);
            r_frame_error <= w_short || w_long;
        end
    end

    // Running tracker; restarts at every frame boundary, good or bad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin_cnt <= 8'd0;
            r_max     <= '0;
            r_idx     <= 8'd0;
        end else if (w_scan_hs) begin
            if (s_axis_tlast || w_at_last_bin) begin
                r_bin_cnt <= 8'd0;
                r_max     <= '0;
                r_idx     <= 8'd0;
            end else begin
                r_bin_cnt <= r_bin_cnt + 8'd1;
                r_max     <= w_upd_max;
                r_idx     <= w_upd_idx;
            end
        end else if (w_drop_hs && s_axis_tlast) begin
            r_bin_cnt <= 8'd0;
        end
    end

    // Report shifter: index byte first, then power bytes from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_rep_shift <= '0;
            r_byte_cnt  <= 8'd0;
        end else if (w_good) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_upd_idx;
            r_out_last  <= 1'b0;
            r_rep_shift <= w_pow_pad;
            r_byte_cnt  <= 8'd0;
        end else if (w_out_hs) begin
            if (r_out_last) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_out_data  <= '0;
            end else begin
                r_out_data  <= r_rep_shift[c_REP_BITS-1 -: 8];
                r_rep_shift <= r_rep_shift << 8;
                r_byte_cnt  <= r_byte_cnt + 8'd1;
                r_out_last  <= ((r_byte_cnt + 8'd1) == c_LAST_BYTE);
            end
        end
    end

    assign s_axis_tready = r_in_ready;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tlast  = r_out_last;
    assign frame_error   = r_frame_error;

endmodule
`default_nettype wire

// File: doc/cbf_spectrum_peak_reporter.md
Name: cbf_spectrum_peak_reporter

Overview:
- Sink for the serialized CBF power-spectrum stream. Each frame carries PHI_SCAN_NUM_STEPS power words, one per scan angle, in ascending angle order.
- Finds the peak (argmax) power bin of each frame and emits a compact byte-wide report packet: peak index followed by the peak power, MSB first.
- The 8-bit output feeds the host UART/USB byte path. This is the return leg of the byte stream that enters the spectrum estimator.

Parameters:
- WORD_LENGTH_POWER, 88, width of one power word (unsigned).
- PHI_SCAN_NUM_STEPS, 51, number of power words per spectrum frame; must be 2..255.
- WORD_LENGTH_OUT, 8, output byte width; fixed at 8.
- POWER_BYTES, ceil(WORD_LENGTH_POWER/8) = 11, derived; number of power bytes per report.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  WORD_LENGTH_POWER  power word, unsigned
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  asserted on the last word of a spectrum frame
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  8  report byte
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  asserted on the last byte of a report
- m_axis_tready  in  1  output ready
- frame_error  out  1  one-cycle pulse on a malformed frame

Behaviour:
- Reset (rst_n low, asynchronous): state SCAN; bin counter, max power and max index = 0.
- Outputs under reset: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_error=0. s_axis_tready rises on the first clk edge after deassertion.
- State SCAN:
  - s_axis_tready=1; m_axis_tvalid=0.
  - A handshake is s_axis_tvalid && s_axis_tready.
  - On each handshake at bin counter k: if k==0 or tdata > max (unsigned, strict), load max=tdata and idx=k. Ties therefore keep the lowest index.
- End of frame, evaluated at each handshake:
  - k==N-1 and tlast=1: valid frame. Latch the updated max/idx into the report register, clear the counter, go to EMIT.
  - tlast=1 and k<N-1: short frame. Pulse frame_error, discard the frame, clear the counter, stay in SCAN. No report is sent.
  - k==N-1 and tlast=0: long frame. Pulse frame_error, go to DROP.
- State DROP:
  - s_axis_tready=1; all words are discarded.
  - On a handshake with tlast=1, clear the counter and return to SCAN. The next word is bin 0.
- State EMIT:
  - s_axis_tready=0, so upstream back-pressures.
  - Sends 1+POWER_BYTES bytes. Byte 0 = peak index (zero-extended to 8 bits). Bytes 1..POWER_BYTES = peak power, MSB byte first, with the most significant byte zero-padded when WORD_LENGTH_POWER is not a multiple of 8.
  - m_axis_tlast=1 on the final byte only.
  - m_axis_tvalid and m_axis_tdata are driven from registers. They hold stable while valid && !ready.
  - The byte counter advances only on an output handshake.
  - After the final-byte handshake: m_axis_tvalid=0, return to SCAN.
- Latency: the first report byte is valid on the cycle after the last input word's handshake. With m_axis_tready held high, the report takes 12 cycles (1+POWER_BYTES).
- Throughput: s_axis_tready is low throughout EMIT. Back-to-back frames incur 12 stall cycles with continuous output ready.
- Tracking vs. report register: the running max/idx registers are cleared on frame completion and are independent of the latched report. A malformed frame never corrupts a report in flight; such a frame cannot start during EMIT.
- Reset mid-EMIT: the packet is abandoned immediately and m_axis_tvalid=0. There is no partial resume after reset.
- frame_error is registered and is high for exactly one cycle per malformed frame.

Test Plan:
- Basic peak (N=4, WLP=16): words 5, 900, 17, 3, tlast on the 4th -> bytes 0x01,0x03,0x84, tlast on the 3rd byte; frame_error stays 0.
- Tie and first-bin cases (default params):
  - 51 words all 0x7 -> index byte 0x00; power bytes are ten 0x00 followed by 0x07.
  - Max at bin 50 only -> index 0x32.
  - Full-scale power 2^88-1 -> power bytes 11× 0xFF.
- Output back-pressure: m_axis_tready toggles 1010… and is held low 20 cycles mid-packet -> every byte delivered exactly once and in order. tdata/tvalid stable while stalled. s_axis_tready=0 until the final byte is accepted.
- Short frame (N=4): tlast on the 2nd word -> frame_error pulse of 1 cycle, no report. The following correct frame 1,2,9,4 -> report index 0x02, power byte 0x09.
- Long frame (N=4): 6 words, tlast only on the 6th -> frame_error pulses on the 4th handshake; words 5–6 are dropped. The next good frame reports correctly.
- Reset mid-packet: assert rst_n low after byte 3 of a report -> m_axis_tvalid=0 asynchronously. After release, a fresh frame produces a complete, correct report.
